// File: rtl/twi_slave.sv
// TWI (I2C) target: synchronizes raw SCL/SDA, detects START/STOP, matches a 7-bit
// address, and moves data bytes through a strobe interface. SDA is open-drain via sda_oe.
`timescale 1ns/1ps
module twi_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       rx_ack_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rd_req,
  input  logic [7:0] tx_data,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA; flops reset high to match an idle bus.
  logic [1:0] pad_raw;
  logic [1:0] sync_bits;
  logic [1:0] hist_bits;

  assign pad_raw = {scl_i, sda_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      logic hist_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          hist_reg <= 1'b1;
        end else begin
          meta_reg <= pad_raw[gi];
          sync_reg <= meta_reg;
          hist_reg <= sync_reg;
        end
      end

      assign sync_bits[gi] = sync_reg;
      assign hist_bits[gi] = hist_reg;
    end
  endgenerate

  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = sync_bits[1];
  assign scl_h     = hist_bits[1];
  assign sda_s     = sync_bits[0];
  assign sda_h     = hist_bits[0];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       addr_hit_reg, addr_hit_next;
  logic       rw_reg, rw_next;
  logic       busy_reg, busy_next;
  // Splits each ACK slot into "waiting for the fall that starts it" and "driving it".
  logic       phase_reg, phase_next;
  logic       rd_req_next;
  logic [7:0] shifted_in;

  assign shifted_in = {shift_reg[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      rx_data_reg  <= 8'h00;
      sda_oe_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
      addr_hit_reg <= 1'b0;
      rw_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      phase_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      sda_oe_reg   <= sda_oe_next;
      rx_valid_reg <= rx_valid_next;
      addr_hit_reg <= addr_hit_next;
      rw_reg       <= rw_next;
      busy_reg     <= busy_next;
      phase_reg    <= phase_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    sda_oe_next   = sda_oe_reg;
    rx_valid_next = 1'b0;
    addr_hit_next = 1'b0;
    rw_next       = rw_reg;
    busy_next     = busy_reg;
    phase_next    = phase_reg;
    rd_req_next   = 1'b0;

    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = 3'd0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
      phase_next   = 1'b0;
    end else if (stop_det) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
      phase_next  = 1'b0;
    end else begin
      case (state_reg)
        ADDR: if (scl_rise) begin
          shift_next   = shifted_in;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (shifted_in[7:1] == SLAVE_ADDR) begin
              rw_next    = shifted_in[0];
              state_next = ADDR_ACK;
              phase_next = 1'b0;
            end else begin
              state_next = WAIT;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase_reg) begin
            sda_oe_next   = 1'b1;
            addr_hit_next = 1'b1;
            busy_next     = 1'b1;
            phase_next    = 1'b1;
            if (rw_reg) begin
              rd_req_next = 1'b1;
              shift_next  = tx_data;
            end
          end else begin
            phase_next = 1'b0;
            if (rw_reg) begin
              sda_oe_next  = ~shift_reg[7];
              shift_next   = {shift_reg[6:0], 1'b0};
              bit_cnt_next = 3'd1;
              state_next   = RD_DATA;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 3'd0;
              state_next   = WR_DATA;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_next   = shifted_in;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            rx_data_next  = shifted_in;
            rx_valid_next = 1'b1;
            state_next    = WR_ACK;
            phase_next    = 1'b0;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!phase_reg) begin
            sda_oe_next = rx_ack_en;
            phase_next  = 1'b1;
          end else begin
            sda_oe_next  = 1'b0;
            phase_next   = 1'b0;
            bit_cnt_next = 3'd0;
            state_next   = WR_DATA;
          end
        end
        // Counter wraps to 0 once all 8 bits are on the bus; that fall opens the ACK slot.
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_reg == 3'd0) begin
            sda_oe_next = 1'b0;
            phase_next  = 1'b0;
            state_next  = RD_ACK;
          end else begin
            sda_oe_next  = ~shift_reg[7];
            shift_next   = {shift_reg[6:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              phase_next = 1'b1;
            end else begin
              state_next  = WAIT;
              sda_oe_next = 1'b0;
              busy_next   = 1'b0;
            end
          end else if (scl_fall && phase_reg) begin
            rd_req_next  = 1'b1;
            sda_oe_next  = ~tx_data[7];
            shift_next   = {tx_data[6:0], 1'b0};
            bit_cnt_next = 3'd1;
            phase_next   = 1'b0;
            state_next   = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign rd_req   = rd_req_next;
  assign addr_hit = addr_hit_reg;
  assign rw       = rw_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_twi_slave.sv
// Directed bench for twi_slave: a bit-banged bus master drives SCL/SDA with a wired-AND
// SDA, and each scenario task checks bus-visible results and strobe counts inline.
`timescale 1ns/1ps
module tb_twi_slave;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       rx_ack_en;
  logic [7:0] tx_data;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_req;
  logic       addr_hit;
  logic       rw;
  logic       busy;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  twi_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .rx_ack_en(rx_ack_en),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_req   (rd_req),
    .tx_data  (tx_data),
    .addr_hit (addr_hit),
    .rw       (rw),
    .busy     (busy)
  );

  int compared = 0;
  int mismatched = 0;

  int rx_cnt = 0;
  int rd_cnt = 0;
  int hit_cnt = 0;
  int oe_cyc = 0;
  logic [7:0] rx_hist [0:15];
  logic [7:0] tx_tab [0:3];

  // tx_data is refreshed from the table before the request count advances, so the
  // byte on tx_data while rd_req is high belongs to that request.
  always @(negedge clk) begin
    tx_data = tx_tab[rd_cnt % 4];
    if (rd_req) rd_cnt++;
    if (rx_valid) begin
      rx_hist[rx_cnt % 16] = rx_data;
      rx_cnt++;
    end
    if (addr_hit) hit_cnt++;
    if (sda_oe) oe_cyc++;
  end

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    qwait(); sda_m = 1'b1;
    qwait(); scl_m = 1'b1;
    qwait(); sda_m = 1'b0;
    qwait(); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    qwait(); sda_m = 1'b0;
    qwait(); scl_m = 1'b1;
    qwait(); sda_m = 1'b1;
    qwait();
  endtask

  task automatic send_bit(input logic b, output logic sampled);
    qwait(); sda_m = b;
    qwait(); scl_m = 1'b1;
    qwait(); sampled = sda_bus;
    qwait(); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    acked = (s == 1'b0);
    $display("write 0x%02h ack=%0d", d, acked);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(ack ? 1'b0 : 1'b1, s);
    $display("read 0x%02h master_ack=%0d", d, ack);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ack_en = 1'b1;
    for (int i = 0; i < 4; i++) tx_tab[i] = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    compared++; if (rd_req !== 1'b0) begin mismatched++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    compared++; if (addr_hit !== 1'b0) begin mismatched++; $display("FAIL reset_addr_hit: got %b want 0", addr_hit); end
    compared++; if (rw !== 1'b0) begin mismatched++; $display("FAIL reset_rw: got %b want 0", rw); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int rx0 = rx_cnt;
    int h0 = hit_cnt;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'hA5, a1);
    write_byte(8'h3C, a2);
    compared++; if (a0 !== 1'b1) begin mismatched++; $display("FAIL write_addr_ack: got %b want 1", a0); end
    compared++; if (a1 !== 1'b1) begin mismatched++; $display("FAIL write_d0_ack: got %b want 1", a1); end
    compared++; if (a2 !== 1'b1) begin mismatched++; $display("FAIL write_d1_ack: got %b want 1", a2); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL write_busy_mid: got %b want 1", busy); end
    compared++; if (rw !== 1'b0) begin mismatched++; $display("FAIL write_rw: got %b want 0", rw); end
    bus_stop();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
    compared++; if (hit_cnt - h0 != 1) begin mismatched++; $display("FAIL write_hit_count: got %0d want 1", hit_cnt - h0); end
    compared++; if (rx_cnt - rx0 != 2) begin mismatched++; $display("FAIL write_rx_count: got %0d want 2", rx_cnt - rx0); end
    compared++; if (rx_hist[rx0 % 16] !== 8'hA5) begin mismatched++; $display("FAIL write_rx0: got %h want a5", rx_hist[rx0 % 16]); end
    compared++; if (rx_hist[(rx0 + 1) % 16] !== 8'h3C) begin mismatched++; $display("FAIL write_rx1: got %h want 3c", rx_hist[(rx0 + 1) % 16]); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int rx0 = rx_cnt;
    int h0 = hit_cnt;
    int oe0 = oe_cyc;
    bus_start();
    write_byte(8'hA2, a0);
    write_byte(8'h55, a1);
    compared++; if (a0 !== 1'b0) begin mismatched++; $display("FAIL mismatch_addr_ack: got %b want 0", a0); end
    compared++; if (a1 !== 1'b0) begin mismatched++; $display("FAIL mismatch_data_ack: got %b want 0", a1); end
    compared++; if (oe_cyc - oe0 != 0) begin mismatched++; $display("FAIL mismatch_sda_driven: got %0d cycles want 0", oe_cyc - oe0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mismatch_busy: got %b want 0", busy); end
    bus_stop();
    compared++; if (rx_cnt - rx0 != 0) begin mismatched++; $display("FAIL mismatch_rx_count: got %0d want 0", rx_cnt - rx0); end
    compared++; if (hit_cnt - h0 != 0) begin mismatched++; $display("FAIL mismatch_hit_count: got %0d want 0", hit_cnt - h0); end
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] d0, d1;
    int r0 = rd_cnt;
    tx_tab[r0 % 4] = 8'hC3;
    tx_tab[(r0 + 1) % 4] = 8'h7E;
    bus_start();
    write_byte(8'hA1, a0);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    compared++; if (a0 !== 1'b1) begin mismatched++; $display("FAIL read_addr_ack: got %b want 1", a0); end
    compared++; if (rw !== 1'b1) begin mismatched++; $display("FAIL read_rw: got %b want 1", rw); end
    compared++; if (d0 !== 8'hC3) begin mismatched++; $display("FAIL read_byte0: got %h want c3", d0); end
    compared++; if (d1 !== 8'h7E) begin mismatched++; $display("FAIL read_byte1: got %h want 7e", d1); end
    compared++; if (rd_cnt - r0 != 2) begin mismatched++; $display("FAIL read_req_count: got %0d want 2", rd_cnt - r0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL read_busy_after_nack: got %b want 0", busy); end
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("FAIL read_sda_released: got %b want 0", sda_oe); end
    bus_stop();
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [7:0] d0;
    int rx0 = rx_cnt;
    int h0 = hit_cnt;
    int r0 = rd_cnt;
    tx_tab[r0 % 4] = 8'hAA;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h11, a1);
    bus_start();
    write_byte(8'hA1, a2);
    read_byte(1'b0, d0);
    bus_stop();
    compared++; if (a2 !== 1'b1) begin mismatched++; $display("FAIL rs_addr_ack: got %b want 1", a2); end
    compared++; if (rx_cnt - rx0 != 1) begin mismatched++; $display("FAIL rs_rx_count: got %0d want 1", rx_cnt - rx0); end
    compared++; if (rx_hist[rx0 % 16] !== 8'h11) begin mismatched++; $display("FAIL rs_rx_data: got %h want 11", rx_hist[rx0 % 16]); end
    compared++; if (hit_cnt - h0 != 2) begin mismatched++; $display("FAIL rs_hit_count: got %0d want 2", hit_cnt - h0); end
    compared++; if (rw !== 1'b1) begin mismatched++; $display("FAIL rs_rw: got %b want 1", rw); end
    compared++; if (rd_cnt - r0 != 1) begin mismatched++; $display("FAIL rs_req_count: got %0d want 1", rd_cnt - r0); end
    compared++; if (d0 !== 8'hAA) begin mismatched++; $display("FAIL rs_read_data: got %h want aa", d0); end
  endtask

  task automatic test_nack();
    logic a0, a1;
    int rx0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, a0);
    rx_ack_en = 1'b0;
    write_byte(8'h99, a1);
    bus_stop();
    rx_ack_en = 1'b1;
    compared++; if (a0 !== 1'b1) begin mismatched++; $display("FAIL nack_addr_ack: got %b want 1", a0); end
    compared++; if (a1 !== 1'b0) begin mismatched++; $display("FAIL nack_data_ack: got %b want 0", a1); end
    compared++; if (rx_cnt - rx0 != 1) begin mismatched++; $display("FAIL nack_rx_count: got %0d want 1", rx_cnt - rx0); end
    compared++; if (rx_hist[rx0 % 16] !== 8'h99) begin mismatched++; $display("FAIL nack_rx_data: got %h want 99", rx_hist[rx0 % 16]); end
  endtask

  task automatic test_abort();
    logic a0, a1, a2, s;
    int rx0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, a0);
    for (int i = 0; i < 4; i++) send_bit(i[0], s);
    bus_stop();
    $display("stop after 4 data bits");
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", busy); end
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("FAIL abort_sda_oe: got %b want 0", sda_oe); end
    compared++; if (rx_cnt - rx0 != 0) begin mismatched++; $display("FAIL abort_rx_count: got %0d want 0", rx_cnt - rx0); end

    tx_tab[rd_cnt % 4] = 8'h0F;
    bus_start();
    write_byte(8'hA1, a0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    compared++; if (sda_oe !== 1'b1) begin mismatched++; $display("FAIL midread_msb_drive: got %b want 1", sda_oe); end
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++; if (sda_oe !== 1'b0) begin mismatched++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    $display("reset mid-read");

    rx0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, a1);
    write_byte(8'h01, a2);
    bus_stop();
    compared++; if (a1 !== 1'b1) begin mismatched++; $display("FAIL recover_addr_ack: got %b want 1", a1); end
    compared++; if (a2 !== 1'b1) begin mismatched++; $display("FAIL recover_data_ack: got %b want 1", a2); end
    compared++; if (rx_cnt - rx0 != 1) begin mismatched++; $display("FAIL recover_rx_count: got %0d want 1", rx_cnt - rx0); end
    compared++; if (rx_hist[rx0 % 16] !== 8'h01) begin mismatched++; $display("FAIL recover_rx_data: got %h want 01", rx_hist[rx0 % 16]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_back_to_back();
    test_nack();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
